montgomery_multiplier: RTL and testbench



---
 rtl/montgomery_multiplier.sv | 121 ++++++++++++
 tb/tb_montgomery_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/montgomery_multiplier.sv
// Radix-2 bit-serial Montgomery multiplier: out = a*b*R^-1 mod modulant, k+2 cycles per product.
// Optional operand/parameter checking is enabled by defining MONT_PARAM_CHECK_EN.
module montgomery_multiplier #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] r_half,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned SW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, LOOP, CORRECT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_n;
  logic [DATA_WIDTH-1:0] r_rh;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [SW-1:0]         r_s;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [SW-1:0]         w_t0;
  logic [SW-1:0]         w_t;
  logic [SW-1:0]         w_corr;
  logic                  w_last;
  logic                  w_params_ok;

  // One Montgomery iteration: add b if the current a bit is set, make even with N, halve.
  assign w_t0   = r_s + (((r_a & r_mask) != '0) ? SW'(r_b) : '0);
  assign w_t    = w_t0[0] ? (w_t0 + SW'(r_n)) : w_t0;
  // Mask reaching the MSB also ends the loop so an illegal r_half of 0 cannot hang.
  assign w_last = (r_mask == r_rh) || r_mask[DATA_WIDTH-1];
  assign w_corr = (r_s >= SW'(r_n)) ? (r_s - SW'(r_n)) : r_s;

`ifdef MONT_PARAM_CHECK_EN
  logic [DATA_WIDTH:0] w_rh_x2;
  assign w_rh_x2     = {r_half, 1'b0};
  assign w_params_ok = modulant[0]
                    && (r_half != '0)
                    && ((r_half & (r_half - DATA_WIDTH'(1))) == '0)
                    && (modulant >= r_half)
                    && ({1'b0, modulant} < w_rh_x2)
                    && (a < modulant)
                    && (b < modulant);
`else
  assign w_params_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_rh    <= '0;
      r_mask  <= '0;
      r_s     <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_params_ok) begin
              r_a     <= a;
              r_b     <= b;
              r_n     <= modulant;
              r_rh    <= r_half;
              r_s     <= '0;
              r_mask  <= DATA_WIDTH'(1);
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= LOOP;
`ifdef MONT_PARAM_CHECK_EN
              r_error <= 1'b0;
            end else begin
              r_error <= 1'b1;
`endif
            end
          end
        end
        LOOP: begin
          r_s <= w_t >> 1;
          if (w_last) begin
            r_state <= CORRECT;
          end else begin
            r_mask <= r_mask << 1;
          end
        end
        CORRECT: begin
          r_out   <= w_corr[DATA_WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

endmodule

// File: tb/tb_montgomery_multiplier.sv
// Directed, table-driven bench for montgomery_multiplier with hand-computed Montgomery products.
module tb_montgomery_multiplier;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] modulant;
  logic [W-1:0] r_half;
  logic [W-1:0] out;
  logic         busy;
  logic         done;
  logic         error;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vn;
    logic [W-1:0] vrh;
    logic [W-1:0] vexp;
  } vec_t;

  vec_t vecs[8];

  montgomery_multiplier #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .modulant (modulant),
    .r_half   (r_half),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int k_of(input logic [W-1:0] rh);
    int k = 0;
    for (int i = 0; i < int'(W); i++) if (rh[i]) k = i + 1;
    return k;
  endfunction

  // Issue one start pulse; lat counts edges after the accepting edge until done is seen.
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tn,
                     input logic [W-1:0] trh, output logic [W-1:0] res, output int lat,
                     output logic busy0);
    @(negedge clk);
    a = ta; b = tb; modulant = tn; r_half = trh; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = out;
  endtask

  initial begin
    logic [W-1:0] res;
    int           lat;
    logic         busy0;
    int           done_cnt;
    int           dbl_done;
    logic         prev_done;

    vecs[0] = '{8'd5,   8'd7,   8'd13,  8'd8,   8'd3};
    vecs[1] = '{8'd5,   8'd9,   8'd13,  8'd8,   8'd2};
    vecs[2] = '{8'd1,   8'd1,   8'd13,  8'd8,   8'd9};
    vecs[3] = '{8'd254, 8'd254, 8'd255, 8'd128, 8'd1};
    vecs[4] = '{8'd0,   8'd12,  8'd13,  8'd8,   8'd0};
    vecs[5] = '{8'd12,  8'd12,  8'd13,  8'd8,   8'd9};
    vecs[6] = '{8'd3,   8'd5,   8'd7,   8'd4,   8'd1};
    vecs[7] = '{8'd2,   8'd3,   8'd255, 8'd128, 8'd6};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; modulant = 8'd13; r_half = 8'd8;
    repeat (2) @(negedge clk);
    chk("reset_out",   32'(out),   32'd0);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_error", 32'(error), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].va, vecs[i].vb, vecs[i].vn, vecs[i].vrh, res, lat, busy0);
      chk($sformatf("vec%0d_out", i), 32'(res), 32'(vecs[i].vexp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(k_of(vecs[i].vrh) + 1));
      chk($sformatf("vec%0d_busy_first", i), 32'(busy0), 32'd1);
      chk($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_error", i), 32'(error), 32'd0);
    end

    // Start pulse with new a during LOOP must be ignored.
    @(negedge clk);
    a = 8'd5; b = 8'd7; modulant = 8'd13; r_half = 8'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ignore_out", 32'(out), 32'd3);
    chk("busy_ignore_latency", 32'(lat), 32'd5);
    repeat (3) @(negedge clk);
    chk("busy_ignore_no_restart", 32'(busy), 32'd0);
    chk("busy_ignore_done_held", 32'(done), 32'd1);

    // Reset in LOOP cycle 1 clears everything immediately.
    a = 8'd5; b = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_out",  32'(out),  32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    run(8'd5, 8'd9, 8'd13, 8'd8, res, lat, busy0);
    chk("post_reset_out", 32'(res), 32'd2);
    chk("post_reset_latency", 32'(lat), 32'd5);

    // Start held high: back-to-back runs, done high one cycle each, period k+2.
    @(negedge clk);
    a = 8'd0; b = 8'd12; modulant = 8'd13; r_half = 8'd8; start = 1'b1;
    done_cnt = 0; dbl_done = 0; prev_done = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (done && prev_done) dbl_done++;
      prev_done = done;
    end
    start = 1'b0;
    chk("hold_done_count", 32'(done_cnt), 32'd3);
    chk("hold_done_width", 32'(dbl_done), 32'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_final_done", 32'(done), 32'd1);
    chk("hold_final_out",  32'(out),  32'd0);

`ifndef MONT_PARAM_CHECK_EN
    // r_half of 0 must still terminate after DATA_WIDTH iterations.
    run(8'd5, 8'd7, 8'd13, 8'd0, res, lat, busy0);
    chk("rhalf0_latency", 32'(lat), 32'(W + 1));
    chk("rhalf0_error", 32'(error), 32'd0);
`else
    // Even modulus rejected; valid start afterwards clears the flag.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    a = 8'd5; b = 8'd7; modulant = 8'd12; r_half = 8'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pchk_error", 32'(error), 32'd1);
    chk("pchk_done",  32'(done),  32'd0);
    chk("pchk_busy",  32'(busy),  32'd0);
    run(8'd5, 8'd7, 8'd13, 8'd8, res, lat, busy0);
    chk("pchk_valid_out",   32'(res),   32'd3);
    chk("pchk_valid_error", 32'(error), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
